cpu_fwd_scoreboard: RTL and testbench
=====================================

Name: cpu_fwd_scoreboard

Overview:
- Parametrised successor of the single-pair forwarding input bundle.
- Owns a shift-register scoreboard of in-flight destination registers across NUM_STAGES post-issue pipeline stages.
- For each of NUM_RP decode-stage read ports, produces a forwarding-source select, or a load-use/multi-cycle hazard stall.
- Sits between decode and execute; drives the operand muxes and the decode/fetch hold.

Parameters:
- NUM_REGS, 16, architectural register count; REG_W = $clog2(NUM_REGS).
- NUM_RP, 2, decode read ports checked per cycle.
- NUM_STAGES, 3, tracked stages (0 = EX, 1 = COMMIT, 2 = WB). Minimum 1.
- LAT_W, 2, width of the result-latency field.
- ZERO_REG, 1, register 0 is hard-wired zero; it never matches and never stalls.
- SEL_W, $clog2(NUM_STAGES+1), select width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- stall_in  in  1  external pipeline freeze (memory wait)
- flush_mask  in  NUM_STAGES  per-stage squash; bit k invalidates stage k
- issue_valid  in  1  instruction leaving decode this cycle
- issue_rd  in  REG_W  its destination register
- issue_we  in  1  it writes the register file
- issue_lat  in  LAT_W  cycles until result forwardable (1 = ALU, 2 = load); 0 is treated as 1
- rp_addr  in  NUM_RP*REG_W  decode source register addresses
- rp_used  in  NUM_RP  source actually read
- fwd_sel  out  NUM_RP*SEL_W  0 = register file, k+1 = stage k result
- hazard_stall  out  1  hold decode and insert a bubble
- hazard_cycles  out  16  saturating count of hazard_stall cycles

Behaviour:
- State: NUM_STAGES entries {valid, rd, we, lat}, plus hazard_cycles. On reset_n=0 at the clock edge:
  - all valid bits are 0 and hazard_cycles is 0;
  - as a result, fwd_sel is 0 and hazard_stall is 0 in the following cycle.
- Ready rule: entry in stage k is forwardable iff lat <= k+1, with lat values above NUM_STAGES clamped to NUM_STAGES.
- Match, per port p, combinational with no state:
  - Ignore the port if rp_used[p]=0, or if ZERO_REG=1 and rp_addr[p]=0.
  - Scan stages from 0 (youngest) to NUM_STAGES-1. The first entry with valid && we && rd==rp_addr[p] wins.
  - Winner ready: fwd_sel[p]=k+1. Winner not ready: port hazard, and fwd_sel[p]=0.
  - No winner: fwd_sel[p]=0.
  - A younger not-ready match shadows an older ready one, so the port still hazards.
- hazard_stall = OR of the port hazards. It is purely combinational from the registered state plus the rp_* inputs.
- Sequential update, evaluated in priority order:
  1. reset_n=0 clears all state.
  2. stall_in=1: entries hold; flush_mask is still applied.
  3. hazard_stall=1: entries shift, and stage 0 loads a bubble (valid=0). issue_valid is ignored.
  4. Otherwise entries shift; stage 0 loads {issue_valid, issue_rd, issue_we, issue_lat}.
  - The entry shifted out of stage NUM_STAGES-1 is retired; the register file writes at the end of that stage.
- Flush: flush_mask is applied before the shift, so a squashed entry moves on as a bubble.
  - flush_mask[0] with issue_valid in the same cycle does not squash the incoming instruction.
- hazard_cycles increments each cycle with hazard_stall=1 and stall_in=0, and saturates at 16'hFFFF.
- A reset asserted mid-hazard takes effect at that edge; no partial entries survive.

Decomposition:
- Package cpu_fwd_pkg:
  - fwd_entry_t struct {valid, rd, we, lat};
  - SEL_RF = 0 constant;
  - function fwd_ready(lat, stage).
- Sub-module cpu_fwd_match: one priority scan for one port (entries and address in; sel and hazard out), instantiated NUM_RP times by a generate loop.
- The top level holds the shift register and the counter.

Test Plan:
- Reset with all inputs X except reset_n=0 for 2 cycles -> all fwd_sel=0, hazard_stall=0, hazard_cycles=0.
- ALU back-to-back: issue r3 with lat=1, next cycle rp_addr[0]=3 -> fwd_sel[0]=1. One cycle later -> 2. One more -> 3. After retirement -> 0.
- Load-use: issue r5 with lat=2, next cycle rp_addr[1]=5 -> hazard_stall=1 for 1 cycle and a bubble is inserted. Next cycle fwd_sel[1]=2 and hazard_cycles=1.
- Shadowing: r4 with lat=1 in stage 1 and r4 with lat=2 in stage 0, reading r4 -> hazard_stall=1. After one shift -> fwd_sel=2, the newest value.
- r0 and ZERO_REG: issue r0 with we=1, read r0 -> fwd_sel=0, no stall.
- stall_in and flush: stall_in=1 for 3 cycles -> entries frozen and hazard_cycles unchanged. Then flush_mask=3'b001 on a pending r7 -> reading r7 gives fwd_sel=0.

Source files
------------

// File: rtl/cpu_fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard: in-flight entry
// layout, the register-file select code and the result-ready rule.
package cpu_fwd_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int LAT_W    = 2;
  localparam int SEL_RF   = 0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic [LAT_W-1:0] lat;
  } fwd_entry_t;

  // A latency of 0 behaves as 1; latencies beyond the tracked depth are
  // clamped so that the oldest stage is always forwardable.
  function automatic logic fwd_ready(input logic [LAT_W-1:0] lat,
                                     input int stage,
                                     input int num_stages);
    int eff;
    eff = (lat == '0) ? 1 : int'(lat);
    if (eff > num_stages) eff = num_stages;
    return (eff <= stage + 1);
  endfunction

endpackage

// File: rtl/cpu_fwd_match.sv
// Priority scan of the in-flight entries for one decode read port: the
// youngest matching writer decides between forwarding and a hazard.
module cpu_fwd_match
  import cpu_fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  fwd_entry_t [NUM_STAGES-1:0] entries,
  input  logic [REG_W-1:0]            addr,
  input  logic                        used,
  output logic [SEL_W-1:0]            sel,
  output logic                        hazard
);

  logic found;

  // Once the youngest match is found, older (possibly ready) copies are
  // shadowed so a not-ready younger writer still stalls the port.
  always_comb begin
    sel    = SEL_W'(SEL_RF);
    hazard = 1'b0;
    found  = 1'b0;
    if (used && !(ZERO_REG != 0 && addr == '0)) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (!found && entries[k].valid && entries[k].we && entries[k].rd == addr) begin
          found = 1'b1;
          if (fwd_ready(entries[k].lat, k, NUM_STAGES)) sel = SEL_W'(k + 1);
          else hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_fwd_scoreboard.sv
// Shift-register scoreboard of in-flight destinations between decode and
// execute; drives operand forwarding selects and the decode hold.
module cpu_fwd_scoreboard
  import cpu_fwd_pkg::*;
#(
  parameter int NUM_RP     = 2,
  parameter int NUM_STAGES = 3,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall_in,
  input  logic [NUM_STAGES-1:0]   flush_mask,
  input  logic                    issue_valid,
  input  logic [REG_W-1:0]        issue_rd,
  input  logic                    issue_we,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic [NUM_RP*REG_W-1:0] rp_addr,
  input  logic [NUM_RP-1:0]       rp_used,
  output logic [NUM_RP*SEL_W-1:0] fwd_sel,
  output logic                    hazard_stall,
  output logic [15:0]             hazard_cycles
);

  fwd_entry_t [NUM_STAGES-1:0] stages_q;
  fwd_entry_t [NUM_STAGES-1:0] stages_d;
  fwd_entry_t [NUM_STAGES-1:0] kept;
  logic       [NUM_RP-1:0]     port_hazard;

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    cpu_fwd_match #(
      .NUM_STAGES(NUM_STAGES),
      .ZERO_REG  (ZERO_REG),
      .SEL_W     (SEL_W)
    ) u_match (
      .entries(stages_q),
      .addr   (rp_addr[p*REG_W +: REG_W]),
      .used   (rp_used[p]),
      .sel    (fwd_sel[p*SEL_W +: SEL_W]),
      .hazard (port_hazard[p])
    );
  end

  assign hazard_stall = |port_hazard;

  // Squash first, then shift: a flushed entry travels on as a bubble, and
  // flushing stage 0 never touches the instruction being issued this cycle.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      kept[k]       = stages_q[k];
      kept[k].valid = stages_q[k].valid & ~flush_mask[k];
    end
    stages_d = kept;
    if (!stall_in) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) stages_d[k] = kept[k-1];
      stages_d[0] = '0;
      if (!hazard_stall) begin
        stages_d[0].valid = issue_valid;
        stages_d[0].rd    = issue_rd;
        stages_d[0].we    = issue_we;
        stages_d[0].lat   = issue_lat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stages_q      <= '0;
      hazard_cycles <= '0;
    end else begin
      stages_q <= stages_d;
      if (hazard_stall && !stall_in && hazard_cycles != 16'hFFFF)
        hazard_cycles <= hazard_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_fwd_scoreboard.sv
// Bench for cpu_fwd_scoreboard: directed scenarios plus random traffic,
// checked against an instruction-list model of the in-flight window.
module tb_cpu_fwd_scoreboard;
  import cpu_fwd_pkg::*;

  localparam int NRP = 2;
  localparam int NS  = 3;
  localparam int SW  = $clog2(NS + 1);
  localparam int RW  = REG_W;
  localparam int LW  = LAT_W;
  localparam int W   = NRP*SW + 1 + 16;

  logic              clk;
  logic              reset_n;
  logic              stall_in;
  logic [NS-1:0]     flush_mask;
  logic              issue_valid;
  logic [RW-1:0]     issue_rd;
  logic              issue_we;
  logic [LW-1:0]     issue_lat;
  logic [NRP*RW-1:0] rp_addr;
  logic [NRP-1:0]    rp_used;
  logic [NRP*SW-1:0] fwd_sel;
  logic              hazard_stall;
  logic [15:0]       hazard_cycles;

  cpu_fwd_scoreboard #(.NUM_RP(NRP), .NUM_STAGES(NS), .ZERO_REG(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_in     (stall_in),
    .flush_mask   (flush_mask),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_we     (issue_we),
    .issue_lat    (issue_lat),
    .rp_addr      (rp_addr),
    .rp_used      (rp_used),
    .fwd_sel      (fwd_sel),
    .hazard_stall (hazard_stall),
    .hazard_cycles(hazard_cycles)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight instructions as a list; each remembers how many stages it has
  // advanced since issue. Bubbles are simply absent from the list.
  typedef struct {
    int rd;
    bit we;
    int lat;
    int stage;
  } instr_t;

  instr_t flight[$];
  int     m_cnt;
  logic [W-1:0] exp_q[$];

  function automatic void port_expect(input int addr, input bit used,
                                      output int sel, output bit haz);
    int best;
    int eff;
    best = -1;
    sel  = 0;
    haz  = 1'b0;
    if (!used || addr == 0) return;
    foreach (flight[i])
      if (flight[i].we && flight[i].rd == addr &&
          (best < 0 || flight[i].stage < flight[best].stage)) best = i;
    if (best >= 0) begin
      eff = (flight[best].lat == 0) ? 1 : flight[best].lat;
      if (eff > NS) eff = NS;
      if (eff <= flight[best].stage + 1) sel = flight[best].stage + 1;
      else haz = 1'b1;
    end
  endfunction

  function automatic void model_advance(input bit haz);
    instr_t n;
    if (!reset_n) begin
      flight.delete();
      m_cnt = 0;
      return;
    end
    for (int i = flight.size() - 1; i >= 0; i--)
      if (flush_mask[flight[i].stage]) flight.delete(i);
    if (!stall_in) begin
      foreach (flight[i]) flight[i].stage++;
      for (int i = flight.size() - 1; i >= 0; i--)
        if (flight[i].stage >= NS) flight.delete(i);
      if (!haz && issue_valid) begin
        n.rd = int'(issue_rd); n.we = issue_we; n.lat = int'(issue_lat); n.stage = 0;
        flight.push_front(n);
      end
      if (haz && m_cnt < 65535) m_cnt++;
    end
  endfunction

  // ---------------- driver ----------------
  logic [SW-1:0] obs_sel0, obs_sel1;
  logic          obs_haz;
  logic [15:0]   obs_cnt;

  task automatic drive(input bit iv, input int rd, input bit we, input int lat,
                       input int a0, input bit u0, input int a1, input bit u1,
                       input bit st = 1'b0, input logic [NS-1:0] fl = '0);
    issue_valid = iv;
    issue_rd    = RW'(rd);
    issue_we    = we;
    issue_lat   = LW'(lat);
    rp_addr     = {RW'(a1), RW'(a0)};
    rp_used     = {u1, u0};
    stall_in    = st;
    flush_mask  = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: predict, sample at negedge, advance model, cross the edge.
  task automatic step();
    int s0, s1;
    bit h0, h1;
    logic [W-1:0] e;
    port_expect(int'(rp_addr[RW-1:0]), rp_used[0], s0, h0);
    port_expect(int'(rp_addr[2*RW-1:RW]), rp_used[1], s1, h1);
    exp_q.push_back({SW'(s1), SW'(s0), h0 | h1, 16'(m_cnt)});
    @(negedge clk);
    e = exp_q.pop_front();
    obs_sel0 = fwd_sel[SW-1:0];
    obs_sel1 = fwd_sel[2*SW-1:SW];
    obs_haz  = hazard_stall;
    obs_cnt  = hazard_cycles;
    if (reset_n) begin
      check("model_fwd_sel", 32'(fwd_sel), 32'(e[W-1:17]));
      check("model_hazard", 32'(hazard_stall), 32'(e[16]));
      check("model_hazard_cycles", 32'(hazard_cycles), 32'(e[15:0]));
    end
    model_advance(h0 | h1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    reset_n     = 1'b0;
    stall_in    = 1'bx;
    flush_mask  = 'x;
    issue_valid = 1'bx;
    issue_rd    = 'x;
    issue_we    = 1'bx;
    issue_lat   = 'x;
    rp_addr     = 'x;
    rp_used     = 'x;
    step();
    step();
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 3, 1, 5, 1);
    step();
    check("reset_sel", 32'(fwd_sel), 0);
    check("reset_hazard", 32'(obs_haz), 0);
    check("reset_cycles", 32'(obs_cnt), 0);

    // ALU back-to-back forwarding through every stage
    drive(1, 3, 1, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 3, 1, 0, 0); step(); check("alu_ex", 32'(obs_sel0), 1);
    step(); check("alu_commit", 32'(obs_sel0), 2);
    step(); check("alu_wb", 32'(obs_sel0), 3);
    step(); check("alu_retired", 32'(obs_sel0), 0);

    // Load-use: one stall cycle, issue ignored, then forward from commit
    drive(1, 5, 1, 2, 0, 0, 0, 0); step();
    drive(1, 6, 1, 1, 0, 0, 5, 1); step(); check("lu_stall", 32'(obs_haz), 1);
    drive(0, 0, 0, 0, 0, 0, 5, 1); step();
    check("lu_fwd", 32'(obs_sel1), 2);
    check("lu_nostall", 32'(obs_haz), 0);
    check("lu_count", 32'(obs_cnt), 1);
    idle(); repeat (3) step();

    // Younger not-ready r4 shadows the older ready copy
    drive(1, 4, 1, 1, 0, 0, 0, 0); step();
    drive(1, 4, 1, 2, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 4, 1, 0, 0); step(); check("shadow_stall", 32'(obs_haz), 1);
    step(); check("shadow_newest", 32'(obs_sel0), 2);
    idle(); repeat (3) step();

    // r0 never forwards or stalls
    drive(1, 0, 1, 2, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 1); step();
    check("r0_sel", 32'(fwd_sel), 0);
    check("r0_hazard", 32'(obs_haz), 0);
    idle(); repeat (3) step();

    // stall_in freezes entries and the counter; flush squashes pending r7
    drive(1, 7, 1, 2, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 7, 1, 0, 0, 1'b1); step();
    c0 = int'(obs_cnt);
    check("frozen_hazard", 32'(obs_haz), 1);
    step(); step();
    check("frozen_still_pending", 32'(obs_haz), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 3'b001); step();
    check("frozen_cycles", 32'(obs_cnt), 32'(c0));
    drive(0, 0, 0, 0, 7, 1, 0, 0); step();
    check("flush_sel", 32'(obs_sel0), 0);
    check("flush_hazard", 32'(obs_haz), 0);
    idle(); repeat (3) step();

    // flush of stage 0 does not squash the instruction issued alongside it
    drive(1, 9, 1, 1, 0, 0, 0, 0, 1'b0, 3'b001); step();
    drive(0, 0, 0, 0, 9, 1, 0, 0); step(); check("flush_keeps_issue", 32'(obs_sel0), 1);
    idle(); repeat (3) step();

    // Random traffic on a narrow register range to provoke many matches
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0,
            ($urandom_range(0, 9) == 0) ? NS'($urandom_range(1, 7)) : '0);
      step();
    end
    reset_n = 1'b1;
    idle(); repeat (3) step();

    // Reset asserted while a load-use hazard is active
    drive(1, 5, 1, 2, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 5, 1, 0, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("midreset_hazard", 32'(obs_haz), 0);
    check("midreset_sel", 32'(obs_sel0), 0);
    check("midreset_cycles", 32'(obs_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
